// File: rtl/tff_bank.sv
// Bank of WIDTH toggle flip-flops: independent toggling, or chained as an up/down
// T-flip-flop counter with parallel load, hold, optional saturation and a terminal-count pulse.
module tff_bank #(
  parameter int WIDTH = 8,
  parameter bit WRAP  = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] tin,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] q,
  output logic             tc
);

  typedef enum logic [1:0] {
    MODE_IND  = 2'b00,
    MODE_UP   = 2'b01,
    MODE_DN   = 2'b10,
    MODE_HOLD = 2'b11
  } mode_t;

  logic [WIDTH-1:0] q_p0;
  logic             tc_p0;
  logic [WIDTH-1:0] q_next;
  logic             tc_next;
  logic [WIDTH-1:0] t_vec;
  logic             at_limit;

  // Rippled T inputs for counting up: bit i toggles when every lower bit is one.
  function automatic logic [WIDTH-1:0] up_toggles(input logic en,
                                                  input logic [WIDTH-1:0] cur);
    logic [WIDTH-1:0] t;
    logic             carry;
    carry = en;
    for (int i = 0; i < WIDTH; i++) begin
      t[i]  = carry;
      carry = carry & cur[i];
    end
    return t;
  endfunction

  // Rippled T inputs for counting down: bit i toggles when every lower bit is zero.
  function automatic logic [WIDTH-1:0] down_toggles(input logic en,
                                                    input logic [WIDTH-1:0] cur);
    logic [WIDTH-1:0] t;
    logic             borrow;
    borrow = en;
    for (int i = 0; i < WIDTH; i++) begin
      t[i]   = borrow;
      borrow = borrow & ~cur[i];
    end
    return t;
  endfunction

  // In saturating builds a step at the limit toggles nothing.
  function automatic logic [WIDTH-1:0] saturate(input logic [WIDTH-1:0] t,
                                                input logic limit);
    if (!WRAP && limit)
      return '0;
    return t;
  endfunction

  always_comb begin
    t_vec    = '0;
    tc_next  = 1'b0;
    at_limit = 1'b0;
    case (mode_t'(mode))
      MODE_IND: begin
        t_vec = tin;
      end
      MODE_UP: begin
        at_limit = &q_p0;
        t_vec    = saturate(up_toggles(tin[0], q_p0), at_limit);
        tc_next  = tin[0] & at_limit;
      end
      MODE_DN: begin
        at_limit = ~|q_p0;
        t_vec    = saturate(down_toggles(tin[0], q_p0), at_limit);
        tc_next  = tin[0] & at_limit;
      end
      MODE_HOLD: begin
        t_vec = '0;
      end
    endcase
    q_next = q_p0 ^ t_vec;
    if (load) begin
      q_next  = din;
      tc_next = 1'b0;
    end
  end

  // Stage p0: flip-flop state and terminal-count register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q_p0  <= '0;
      tc_p0 <= 1'b0;
    end else begin
      q_p0  <= q_next;
      tc_p0 <= tc_next;
    end
  end

  assign q  = q_p0;
  assign tc = tc_p0;

endmodule

// File: tb/tb_tff_bank.sv
// Scoreboard bench for tff_bank: one wrapping and one saturating 4-bit instance
// share stimulus; an arithmetic model predicts both each cycle.
module tb_tff_bank;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] mode;
  logic [3:0] tin;
  logic       load;
  logic [3:0] din;
  logic [3:0] qa, qb;
  logic       tca, tcb;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct packed {
    logic [3:0] q;
    logic       tc;
  } st_t;

  typedef struct packed {
    st_t a;
    st_t b;
  } exp_t;

  st_t  ma, mb;
  exp_t sb[$];

  always #5 clk = ~clk;

  tff_bank #(.WIDTH(4), .WRAP(1'b1)) dut_a (
    .clk(clk), .reset(reset), .mode(mode), .tin(tin), .load(load), .din(din),
    .q(qa), .tc(tca)
  );

  tff_bank #(.WIDTH(4), .WRAP(1'b0)) dut_b (
    .clk(clk), .reset(reset), .mode(mode), .tin(tin), .load(load), .din(din),
    .q(qb), .tc(tcb)
  );

  function automatic st_t model(st_t s, bit wrap, logic [1:0] m, logic [3:0] t,
                                logic l, logic [3:0] d);
    st_t n;
    n.q  = s.q;
    n.tc = 1'b0;
    if (l) begin
      n.q = d;
    end else if (m == 2'b00) begin
      n.q = s.q ^ t;
    end else if (m == 2'b01 && t[0]) begin
      if (s.q == 4'hF) begin
        n.tc = 1'b1;
        n.q  = wrap ? 4'h0 : 4'hF;
      end else begin
        n.q = s.q + 4'd1;
      end
    end else if (m == 2'b10 && t[0]) begin
      if (s.q == 4'h0) begin
        n.tc = 1'b1;
        n.q  = wrap ? 4'hF : 4'h0;
      end else begin
        n.q = s.q - 4'd1;
      end
    end
    return n;
  endfunction

  // Drive one cycle, push the predicted post-edge state, advance past the edge.
  task automatic cyc(input logic [1:0] m, input logic [3:0] t, input logic l,
                     input logic [3:0] d);
    mode = m; tin = t; load = l; din = d;
    ma = model(ma, 1'b1, m, t, l, d);
    mb = model(mb, 1'b0, m, t, l, d);
    sb.push_back('{a: ma, b: mb});
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; mode = 2'b00; tin = 4'h0; load = 1'b1; din = 4'hA;
    @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    n_cmp++;
    if ({qa, tca, qb, tcb} !== {4'h0, 1'b0, 4'h0, 1'b0}) begin
      n_bad++;
      $display("FAIL reset_async: got qa=%h tca=%b qb=%h tcb=%b, want all 0", qa, tca, qb, tcb);
    end
    for (int i = 0; i < 2; i++) begin
      mode = 2'(i); tin = 4'hF; load = 1'b1; din = 4'h5;
      @(posedge clk);
      #1;
      n_cmp++;
      if ({qa, tca, qb, tcb} !== {4'h0, 1'b0, 4'h0, 1'b0}) begin
        n_bad++;
        $display("FAIL reset_hold[%0d]: got qa=%h tca=%b qb=%h tcb=%b, want all 0", i, qa, tca, qb, tcb);
      end
    end
    load = 1'b0; tin = 4'h0; mode = 2'b00;
    reset = 1'b1;
    ma = '0; mb = '0;
  endtask

  task automatic test_independent();
    logic [3:0] pat [3] = '{4'b1010, 4'b1010, 4'b0001};
    exp_t e;
    for (int i = 0; i < 3; i++) begin
      cyc(2'b00, pat[i], 1'b0, 4'h0);
      e = sb.pop_front();
      n_cmp++;
      if ({qa, tca, qb, tcb} !== {e.a.q, e.a.tc, e.b.q, e.b.tc}) begin
        n_bad++;
        $display("FAIL independent[%0d]: got qa=%h tca=%b qb=%h tcb=%b, want %h %b %h %b",
                 i, qa, tca, qb, tcb, e.a.q, e.a.tc, e.b.q, e.b.tc);
      end
    end
    n_cmp++;
    if (qa !== 4'b0001) begin
      n_bad++;
      $display("FAIL independent_final: got qa=%b, want 0001", qa);
    end
  endtask

  task automatic test_up_wrap();
    exp_t e;
    for (int i = 0; i < 4; i++) begin
      if (i == 0) cyc(2'b01, 4'h0, 1'b1, 4'hE);
      else        cyc(2'b01, 4'hF, 1'b0, 4'h0);
      e = sb.pop_front();
      n_cmp++;
      if ({qa, tca, qb, tcb} !== {e.a.q, e.a.tc, e.b.q, e.b.tc}) begin
        n_bad++;
        $display("FAIL up_wrap[%0d]: got qa=%h tca=%b qb=%h tcb=%b, want %h %b %h %b",
                 i, qa, tca, qb, tcb, e.a.q, e.a.tc, e.b.q, e.b.tc);
      end
    end
    n_cmp++;
    if ({qa, tca} !== {4'h1, 1'b0}) begin
      n_bad++;
      $display("FAIL up_wrap_final: got qa=%h tca=%b, want 1 0", qa, tca);
    end
  endtask

  task automatic test_down_sat();
    exp_t e;
    for (int i = 0; i < 5; i++) begin
      if (i == 0)      cyc(2'b10, 4'h0, 1'b1, 4'h1);
      else if (i < 4)  cyc(2'b10, 4'h1, 1'b0, 4'h0);
      else             cyc(2'b10, 4'h0, 1'b0, 4'h0);
      e = sb.pop_front();
      n_cmp++;
      if ({qa, tca, qb, tcb} !== {e.a.q, e.a.tc, e.b.q, e.b.tc}) begin
        n_bad++;
        $display("FAIL down_sat[%0d]: got qa=%h tca=%b qb=%h tcb=%b, want %h %b %h %b",
                 i, qa, tca, qb, tcb, e.a.q, e.a.tc, e.b.q, e.b.tc);
      end
      if (i == 3) begin
        n_cmp++;
        if ({qb, tcb} !== {4'h0, 1'b1}) begin
          n_bad++;
          $display("FAIL down_sat_limit: got qb=%h tcb=%b, want 0 1", qb, tcb);
        end
      end
    end
  endtask

  task automatic test_load_priority();
    exp_t e;
    for (int i = 0; i < 3; i++) begin
      case (i)
        0: cyc(2'b01, 4'h0, 1'b1, 4'hF);
        1: cyc(2'b01, 4'h1, 1'b1, 4'h7);
        default: cyc(2'b01, 4'h1, 1'b0, 4'h0);
      endcase
      e = sb.pop_front();
      n_cmp++;
      if ({qa, tca, qb, tcb} !== {e.a.q, e.a.tc, e.b.q, e.b.tc}) begin
        n_bad++;
        $display("FAIL load_priority[%0d]: got qa=%h tca=%b qb=%h tcb=%b, want %h %b %h %b",
                 i, qa, tca, qb, tcb, e.a.q, e.a.tc, e.b.q, e.b.tc);
      end
    end
  endtask

  task automatic test_async_reset();
    exp_t e;
    cyc(2'b01, 4'h0, 1'b1, 4'h4);
    cyc(2'b01, 4'h1, 1'b0, 4'h0);
    e = sb.pop_front();
    e = sb.pop_front();
    n_cmp++;
    if ({qa, qb} !== {e.a.q, e.b.q} || qa !== 4'h5) begin
      n_bad++;
      $display("FAIL async_setup: got qa=%h qb=%h, want 5 5", qa, qb);
    end
    #2;
    reset = 1'b0;
    #1;
    n_cmp++;
    if ({qa, tca, qb, tcb} !== {4'h0, 1'b0, 4'h0, 1'b0}) begin
      n_bad++;
      $display("FAIL async_mid: got qa=%h tca=%b qb=%h tcb=%b, want all 0", qa, tca, qb, tcb);
    end
    @(posedge clk);
    #1;
    n_cmp++;
    if ({qa, tca, qb, tcb} !== {4'h0, 1'b0, 4'h0, 1'b0}) begin
      n_bad++;
      $display("FAIL async_held: got qa=%h tca=%b qb=%h tcb=%b, want all 0", qa, tca, qb, tcb);
    end
    reset = 1'b1;
    ma = '0; mb = '0;
    cyc(2'b01, 4'h1, 1'b0, 4'h0);
    e = sb.pop_front();
    n_cmp++;
    if ({qa, tca, qb, tcb} !== {e.a.q, e.a.tc, e.b.q, e.b.tc} || qa !== 4'h1) begin
      n_bad++;
      $display("FAIL async_restart: got qa=%h tca=%b qb=%h tcb=%b, want 1 0 1 0", qa, tca, qb, tcb);
    end
  endtask

  task automatic test_hold_switch();
    exp_t e;
    for (int i = 0; i < 4; i++) begin
      case (i)
        0: cyc(2'b11, 4'h0, 1'b1, 4'h3);
        1, 2: cyc(2'b11, 4'hF, 1'b0, 4'h0);
        default: cyc(2'b10, 4'h1, 1'b0, 4'h0);
      endcase
      e = sb.pop_front();
      n_cmp++;
      if ({qa, tca, qb, tcb} !== {e.a.q, e.a.tc, e.b.q, e.b.tc}) begin
        n_bad++;
        $display("FAIL hold_switch[%0d]: got qa=%h tca=%b qb=%h tcb=%b, want %h %b %h %b",
                 i, qa, tca, qb, tcb, e.a.q, e.a.tc, e.b.q, e.b.tc);
      end
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    for (int i = 0; i < 60; i++) begin
      cyc(2'($urandom_range(3)), 4'($urandom), ($urandom_range(7) == 0), 4'($urandom));
      e = sb.pop_front();
      n_cmp++;
      if ({qa, tca, qb, tcb} !== {e.a.q, e.a.tc, e.b.q, e.b.tc}) begin
        n_bad++;
        $display("FAIL back_to_back[%0d]: got qa=%h tca=%b qb=%h tcb=%b, want %h %b %h %b",
                 i, qa, tca, qb, tcb, e.a.q, e.a.tc, e.b.q, e.b.tc);
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    ma = '0; mb = '0;
    test_reset();
    test_independent();
    test_up_wrap();
    test_down_sat();
    test_load_priority();
    test_async_reset();
    test_hold_switch();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
